// File: rtl/gpr_pkg.sv
// Shared types and defaults for the GPR operand-fetch path: FSM states,
// x86 register index codes and the default register geometry.
package gpr_pkg;

    localparam int GPR_DATA_W   = 32;
    localparam int GPR_NUM_REGS = 8;
    localparam int GPR_IDX_W    = 3;

    typedef logic [GPR_IDX_W-1:0] gpr_idx_t;

    typedef enum logic [GPR_IDX_W-1:0] {
        REG_EAX = 3'd0,
        REG_ECX = 3'd1,
        REG_EDX = 3'd2,
        REG_EBX = 3'd3,
        REG_ESP = 3'd4,
        REG_EBP = 3'd5,
        REG_ESI = 3'd6,
        REG_EDI = 3'd7
    } gpr_reg_t;

    typedef enum logic [1:0] {
        IDLE,
        READ_A,
        READ_B,
        DONE
    } gpr_state_t;

endpackage

// File: rtl/gpr_select.sv
// Combinational NUM_REGS:1 register read mux with zero for unimplemented
// indices. Same-edge write forwarding is compiled in by GPR_READ_BYPASS_EN.
module gpr_select
    import gpr_pkg::*;
#(
    parameter int DATA_W   = GPR_DATA_W,
    parameter int NUM_REGS = GPR_NUM_REGS
) (
    input  logic [NUM_REGS*DATA_W-1:0] gpr_flat,
    input  logic [GPR_IDX_W-1:0]       sel,
    input  logic                       wb_valid,
    input  logic [GPR_IDX_W-1:0]       wb_sel,
    input  logic [DATA_W-1:0]          wb_data,
    output logic [DATA_W-1:0]          data
);

    logic [DATA_W-1:0] mux_data;

    always_comb begin
        // NOTE: default assignment first, so indices with no register read 0 and no latch is inferred.
        mux_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(sel) == i) begin
                mux_data = gpr_flat[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef GPR_READ_BYPASS_EN
    logic sel_in_range;
    logic wb_hit;

    assign sel_in_range = (int'(sel) < NUM_REGS);
    assign wb_hit       = wb_valid && (wb_sel == sel) && sel_in_range;
    assign data         = wb_hit ? wb_data : mux_data;
`else
    // Write-back port is kept for a uniform interface; it has no effect here.
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_sel, wb_data};
    assign data      = mux_data;
`endif

endmodule

// File: rtl/gpr_read_port.sv
// Operand fetch between decode and execute: reads one or two GPRs in
// successive cycles and hands them on over valid/ready. Optional macro: GPR_READ_BYPASS_EN.
module gpr_read_port
    import gpr_pkg::*;
#(
    parameter int DATA_W   = GPR_DATA_W,
    parameter int NUM_REGS = GPR_NUM_REGS
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [GPR_IDX_W-1:0]       req_src_a,
    input  logic [GPR_IDX_W-1:0]       req_src_b,
    input  logic                       req_two,
    input  logic [NUM_REGS*DATA_W-1:0] gpr_flat,
    input  logic                       wb_valid,
    input  logic [GPR_IDX_W-1:0]       wb_sel,
    input  logic [DATA_W-1:0]          wb_data,
    output logic                       op_valid,
    input  logic                       op_ready,
    output logic [DATA_W-1:0]          op_a,
    output logic [DATA_W-1:0]          op_b
);

    gpr_state_t        state;
    gpr_idx_t          src_a_q;
    gpr_idx_t          src_b_q;
    logic              two_q;
    gpr_idx_t          rd_sel;
    logic [DATA_W-1:0] rd_data;

    // One read mux serves both capture states.
    assign rd_sel = (state == READ_B) ? src_b_q : src_a_q;

    gpr_select #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_select (
        .gpr_flat (gpr_flat),
        .sel      (rd_sel),
        .wb_valid (wb_valid),
        .wb_sel   (wb_sel),
        .wb_data  (wb_data),
        .data     (rd_data)
    );

    // NOTE: all state here updates with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            src_a_q   <= REG_EAX;
            src_b_q   <= REG_EAX;
            two_q     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            req_ready <= 1'b1;
            op_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        src_a_q   <= req_src_a;
                        src_b_q   <= req_src_b;
                        two_q     <= req_two;
                        req_ready <= 1'b0;
                        state     <= READ_A;
                    end
                end
                READ_A: begin
                    op_a <= rd_data;
                    if (two_q) begin
                        state <= READ_B;
                    end else begin
                        op_b     <= '0;
                        op_valid <= 1'b1;
                        state    <= DONE;
                    end
                end
                READ_B: begin
                    op_b     <= rd_data;
                    op_valid <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (op_ready) begin
                        op_valid  <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    op_valid  <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpr_read_port.sv
// Self-checking bench for gpr_read_port: directed vector table, multi-cycle
// corner sequences and randomized fetches against an array-based model.
module tb_gpr_read_port;
    import gpr_pkg::*;

    localparam int DW = 32;
    localparam int NR = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_src_a;
    logic [2:0]       req_src_b;
    logic             req_two;
    logic [NR*DW-1:0] gpr_flat;
    logic             wb_valid;
    logic [2:0]       wb_sel;
    logic [DW-1:0]    wb_data;
    logic             op_valid;
    logic             op_ready;
    logic [DW-1:0]    op_a;
    logic [DW-1:0]    op_b;

    always #5 clock = ~clock;

    gpr_read_port #(
        .DATA_W   (DW),
        .NUM_REGS (NR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src_a (req_src_a),
        .req_src_b (req_src_b),
        .req_two   (req_two),
        .gpr_flat  (gpr_flat),
        .wb_valid  (wb_valid),
        .wb_sel    (wb_sel),
        .wb_data   (wb_data),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b)
    );

    typedef struct {
        logic [2:0]    src_a;
        logic [2:0]    src_b;
        logic          two;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        int            exp_lat;
    } vec_t;

    vec_t          vecs[8];
    logic [DW-1:0] model_regs[NR];
    int            n_compared = 0;
    int            n_failed   = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [2:0] idx);
        if (int'(idx) < NR) return model_regs[idx];
        return '0;
    endfunction

    task automatic set_reg(input int i, input logic [DW-1:0] v);
        model_regs[i] = v;
        gpr_flat[i*DW +: DW] = v;
    endtask

    task automatic wait_edge();
        @(posedge clock);
        #1;
    endtask

    // Entered in IDLE just after an edge; returns once op_valid is seen or the budget expires.
    task automatic fetch(input logic [2:0] a, input logic [2:0] b, input logic two, input logic early_ready,
                         output logic [DW-1:0] ra, output logic [DW-1:0] rb, output int lat);
        req_valid = 1'b1;
        req_src_a = a;
        req_src_b = b;
        req_two   = two;
        wait_edge();
        req_valid = 1'b0;
        req_src_a = 3'($urandom);
        req_src_b = 3'($urandom);
        req_two   = 1'($urandom);
        op_ready  = early_ready;
        check("req_ready_after_accept", {63'd0, req_ready}, 64'd0);
        lat = 0;
        while (!op_valid && lat < 6) begin
            wait_edge();
            lat++;
        end
        op_ready = 1'b0;
        ra = op_a;
        rb = op_b;
    endtask

    task automatic release_op();
        op_ready = 1'b1;
        wait_edge();
        op_ready = 1'b0;
        check("op_valid_after_release", {63'd0, op_valid}, 64'd0);
        check("req_ready_after_release", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        logic [DW-1:0] ra, rb, ea, eb, bypass_exp;
        int            lat;

        vecs[0] = '{3'd3, 3'd0, 1'b0, 32'h0000_0888, 32'h0, 1};
        vecs[1] = '{3'd0, 3'd2, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 2};
        vecs[2] = '{3'd7, 3'd7, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 2};
        vecs[3] = '{3'd4, 3'd5, 1'b1, 32'hFFFF_FFFF, 32'h0, 2};
        vecs[4] = '{3'd6, 3'd1, 1'b0, 32'h8000_0001, 32'h0, 1};
        vecs[5] = '{3'd1, 3'd0, 1'b1, 32'h0BAD_F00D, 32'h1234_5678, 2};
        vecs[6] = '{3'd5, 3'd4, 1'b0, 32'h0, 32'h0, 1};
        vecs[7] = '{3'd2, 3'd6, 1'b1, 32'hDEAD_BEEF, 32'h8000_0001, 2};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_src_a = '0;
        req_src_b = '0;
        req_two   = 1'b0;
        gpr_flat  = '0;
        wb_valid  = 1'b0;
        wb_sel    = '0;
        wb_data   = '0;
        op_ready  = 1'b0;
        set_reg(REG_EAX, 32'h1234_5678);
        set_reg(REG_ECX, 32'h0BAD_F00D);
        set_reg(REG_EDX, 32'hDEAD_BEEF);
        set_reg(REG_EBX, 32'h0000_0888);
        set_reg(REG_ESP, 32'hFFFF_FFFF);
        set_reg(REG_EBP, 32'h0000_0000);
        set_reg(REG_ESI, 32'h8000_0001);
        set_reg(REG_EDI, 32'hA5A5_A5A5);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_op_valid", {63'd0, op_valid}, 64'd0);
        check("rst_op_a", {32'd0, op_a}, 64'd0);
        check("rst_op_b", {32'd0, op_b}, 64'd0);
        reset = 1'b0;
        wait_edge();

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            fetch(vecs[i].src_a, vecs[i].src_b, vecs[i].two, 1'b0, ra, rb, lat);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_op_a", i), {32'd0, ra}, {32'd0, vecs[i].exp_a});
            check($sformatf("vec%0d_op_b", i), {32'd0, rb}, {32'd0, vecs[i].exp_b});
            release_op();
        end

        // Hold in DONE while registers and request inputs churn
        fetch(3'd0, 3'd2, 1'b1, 1'b0, ra, rb, lat);
        for (int c = 0; c < 5; c++) begin
            for (int r = 0; r < NR; r++) set_reg(r, $urandom);
            req_valid = 1'b1;
            req_src_a = 3'($urandom);
            req_src_b = 3'($urandom);
            req_two   = 1'($urandom);
            wait_edge();
            check("hold_op_a", {32'd0, op_a}, {32'd0, 32'h1234_5678});
            check("hold_op_b", {32'd0, op_b}, {32'd0, 32'hDEAD_BEEF});
            check("hold_op_valid", {63'd0, op_valid}, 64'd1);
            check("hold_req_ready", {63'd0, req_ready}, 64'd0);
        end
        set_reg(REG_EBX, 32'h0000_0999);
        req_src_a = 3'd3;
        req_src_b = 3'd1;
        req_two   = 1'b0;
        op_ready  = 1'b1;
        wait_edge();
        op_ready  = 1'b0;
        check("drain_op_valid", {63'd0, op_valid}, 64'd0);
        check("drain_req_ready", {63'd0, req_ready}, 64'd1);
        wait_edge();
        req_valid = 1'b0;
        check("next_accept_req_ready", {63'd0, req_ready}, 64'd0);
        wait_edge();
        check("next_op_valid", {63'd0, op_valid}, 64'd1);
        check("next_op_a", {32'd0, op_a}, {32'd0, 32'h0000_0999});
        check("next_op_b", {32'd0, op_b}, 64'd0);
        release_op();

        // Reset asserted while in READ_B
        set_reg(REG_EAX, 32'h1234_5678);
        req_valid = 1'b1;
        req_src_a = 3'd0;
        req_src_b = 3'd2;
        req_two   = 1'b1;
        wait_edge();
        req_valid = 1'b0;
        wait_edge();
        reset = 1'b1;
        #1;
        check("midrst_op_valid", {63'd0, op_valid}, 64'd0);
        check("midrst_op_a", {32'd0, op_a}, 64'd0);
        check("midrst_op_b", {32'd0, op_b}, 64'd0);
        check("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            wait_edge();
            check("postrst_op_valid", {63'd0, op_valid}, 64'd0);
            check("postrst_req_ready", {63'd0, req_ready}, 64'd1);
        end

        // Same-edge write to ebx on the READ_A capture edge
`ifdef GPR_READ_BYPASS_EN
        bypass_exp = 32'h0000_0777;
`else
        bypass_exp = 32'h0000_0888;
`endif
        set_reg(REG_EBX, 32'h0000_0888);
        req_valid = 1'b1;
        req_src_a = 3'd3;
        req_two   = 1'b0;
        wait_edge();
        req_valid = 1'b0;
        wb_valid  = 1'b1;
        wb_sel    = 3'd3;
        wb_data   = 32'h0000_0777;
        wait_edge();
        wb_valid = 1'b0;
        set_reg(REG_EBX, 32'h0000_0777);
        check("bypass_op_valid", {63'd0, op_valid}, 64'd1);
        check("bypass_op_a", {32'd0, op_a}, {32'd0, bypass_exp});
        release_op();

        // A write to another register must not disturb the ebx capture
        req_valid = 1'b1;
        req_src_a = 3'd3;
        req_two   = 1'b0;
        wait_edge();
        req_valid = 1'b0;
        wb_valid  = 1'b1;
        wb_sel    = 3'd2;
        wb_data   = 32'h0000_0555;
        wait_edge();
        wb_valid = 1'b0;
        set_reg(REG_EDX, 32'h0000_0555);
        check("nobypass_op_a", {32'd0, op_a}, {32'd0, 32'h0000_0777});
        release_op();

        // Randomized fetches against the array model
        for (int it = 0; it < 40; it++) begin
            logic [2:0] a, b;
            logic       two;
            int         hold;
            for (int r = 0; r < NR; r++) set_reg(r, $urandom);
            a    = 3'($urandom);
            b    = 3'($urandom);
            two  = 1'($urandom);
            hold = int'($urandom_range(0, 3));
            ea   = model_read(a);
            eb   = two ? model_read(b) : '0;
            fetch(a, b, two, 1'($urandom), ra, rb, lat);
            check($sformatf("rnd%0d_lat", it), 64'(lat), two ? 64'd2 : 64'd1);
            check($sformatf("rnd%0d_op_a", it), {32'd0, ra}, {32'd0, ea});
            check($sformatf("rnd%0d_op_b", it), {32'd0, rb}, {32'd0, eb});
            for (int h = 0; h < hold; h++) begin
                for (int r = 0; r < NR; r++) set_reg(r, $urandom);
                wait_edge();
                check($sformatf("rnd%0d_hold_a", it), {32'd0, op_a}, {32'd0, ea});
                check($sformatf("rnd%0d_hold_valid", it), {63'd0, op_valid}, 64'd1);
            end
            release_op();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
